dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameters, one per line as name, default, meaning:
  - ADDR_W, 32, requester address width.
  - MEM_AW, 10, word-address bits reaching memory; legal window is 4*2^MEM_AW bytes.
REQ-002 SHALL have these ports, one per line as name, direction, width, meaning. Clock and reset are clk and rst; rst is asynchronous, active-high.
  - clk  in  1  clock
  - rst  in  1  asynchronous active-high reset
  - p0_valid, p1_valid  in  1  request valid (p0 = CPU data port, p1 = loader/debug port)
  - p0_ready, p1_ready  out  1  request accepted this cycle
  - p0_addr, p1_addr  in  ADDR_W  byte address
  - p0_wdata, p1_wdata  in  32  store data
  - p0_wr, p1_wr  in  1  1 = store, 0 = load
  - p0_ctl, p1_ctl  in  4  MEM_* access code
  - p0_rsp_valid, p1_rsp_valid  out  1  one-cycle response strobe
  - p0_rsp_data, p1_rsp_data  out  32  load result (0 for stores and errors)
  - p0_rsp_err, p1_rsp_err  out  1  misaligned or out-of-window access
  - mem_addr  out  32  address to data memory
  - mem_wdata  out  32  data to data memory
  - mem_wr  out  1  memory write enable
  - mem_ctl  out  4  memory access code
  - mem_rdata  in  32  combinational memory read data
  - err_count  out  8  saturating error counter

Function
REQ-003 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, one transaction at a time.
REQ-004 In IDLE, p*_ready SHALL be asserted combinationally for exactly one winner when any p*_valid=1; the winner's request SHALL be latched at that edge and the FSM SHALL move to ACCESS.
REQ-005 Arbitration SHALL be round-robin: with both valid, the port not granted last wins; the last-grant pointer resets to "p1", so p0 wins the first tie.
REQ-006 In ACCESS, mem_addr/mem_wdata/mem_ctl SHALL come from the latched request; mem_wr SHALL equal the latched wr for exactly this one cycle and be 0 in every other state.
REQ-007 At the end of ACCESS, mem_rdata (loads) or 0 (stores) SHALL be registered into the response register.
REQ-008 In RESP, the owner's rsp_valid SHALL be 1 for exactly one cycle with rsp_data/rsp_err; the other port's rsp_valid SHALL stay 0.
REQ-009 Latency SHALL be fixed: acceptance at edge N gives rsp_valid high in cycle N+2; p*_ready SHALL be 0 in ACCESS and RESP, giving at most one transaction per 3 cycles.
REQ-010 Error detection SHALL apply, with no memory side effect (mem_wr=0) on error, the same 3-cycle timing, rsp_err=1 and rsp_data=0:
  - LW/SW with addr[1:0]!=0;
  - LH/LHU/SH with addr[0]!=0;
  - any addr bit at or above MEM_AW+2 set.
REQ-011 An unknown ctl code SHALL be treated as an error.
REQ-012 err_count SHALL increment on each error response and saturate at 8'hFF.
REQ-013 A requester dropping valid before ready SHALL not be granted; valid held high across a lost arbitration SHALL be granted in the next IDLE cycle.
REQ-014 Outputs to memory in IDLE and RESP SHALL be mem_wr=0, with mem_addr/mem_wdata/mem_ctl holding their last values.

Reset
REQ-015 rst SHALL asynchronously force:
  - state IDLE;
  - all ready/rsp_valid/rsp_err=0, rsp_data=0;
  - mem_wr=0, mem_addr=0, mem_wdata=0, mem_ctl=0;
  - err_count=0;
  - last-grant pointer = p1.
REQ-016 A reset during ACCESS or RESP SHALL abort the transaction with no response, and no write in any cycle while rst is high.

Structure
REQ-017 The MEM_* access codes and FSM state encodings SHALL live in the shared encoding package, used by both this block and the data memory.
REQ-018 The round-robin pick SHALL be a sub-module rr_arb2 (inputs: two valids, last pointer; outputs: one-hot grant).

Verification
REQ-019 p0 SW addr 0x10 data 0xDEADBEEF, then p0 LW 0x10 -> second response rsp_data=0xDEADBEEF, err=0, rsp_valid exactly 2 cycles after each accept.
REQ-020 p0 and p1 both valid continuously with LW requests -> grants alternate p0,p1,p0,p1; first grant p0.
REQ-021 p1 LH addr 0x13 -> rsp_err=1, rsp_data=0, mem_wr never 1, err_count 0->1.
REQ-022 p0 SB addr 0x21 data 0x000000AB over word 0x11223344 at 0x20, then LBU 0x21 -> 0x000000AB; LB after SB 0x80 -> 0xFFFFFF80.
REQ-023 Assert rst during ACCESS of a p0 SW to 0x40 -> no rsp_valid, a subsequent LW 0x40 returns the prior value, err_count=0.
REQ-024 Issue 300 misaligned LW requests -> err_count saturates at 0xFF.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared data-memory encodings: MEM_* access codes and arbiter FSM states.
// Used by the arbiter and by the data memory that decodes mem_ctl.
package dmem_arbiter_pkg;

    localparam logic [3:0] MEM_LB  = 4'h0;
    localparam logic [3:0] MEM_LH  = 4'h1;
    localparam logic [3:0] MEM_LW  = 4'h2;
    localparam logic [3:0] MEM_LBU = 4'h4;
    localparam logic [3:0] MEM_LHU = 4'h5;
    localparam logic [3:0] MEM_SB  = 4'h8;
    localparam logic [3:0] MEM_SH  = 4'h9;
    localparam logic [3:0] MEM_SW  = 4'hA;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResp
    } arb_state_e;

    // Unknown codes count as faulty so they never reach memory.
    function automatic logic ctl_bad(input logic [3:0] ctl, input logic [1:0] lsb);
        case (ctl)
            MEM_LB, MEM_LBU, MEM_SB: ctl_bad = 1'b0;
            MEM_LH, MEM_LHU, MEM_SH: ctl_bad = lsb[0];
            MEM_LW, MEM_SW:          ctl_bad = |lsb;
            default:                 ctl_bad = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the port not granted last wins.
module rr_arb2 (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = {req1_i, req0_i};
        if (req0_i && req1_i) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: one transaction at a time, fixed 3-cycle
// accept/access/respond sequence, alignment and window checking.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    input  logic              p1_valid,
    output logic              p0_ready,
    output logic              p1_ready,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [31:0]       p1_wdata,
    input  logic              p0_wr,
    input  logic              p1_wr,
    input  logic [3:0]        p0_ctl,
    input  logic [3:0]        p1_ctl,
    output logic              p0_rsp_valid,
    output logic              p1_rsp_valid,
    output logic [31:0]       p0_rsp_data,
    output logic [31:0]       p1_rsp_data,
    output logic              p0_rsp_err,
    output logic              p1_rsp_err,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_wr,
    output logic [3:0]        mem_ctl,
    input  logic [31:0]       mem_rdata,
    output logic [7:0]        err_count
);

    arb_state_e        state_q, state_d;
    logic              last_q;
    logic              owner_q;
    logic              wr_q;
    logic              err_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        ctl_q;
    logic [31:0]       rsp_data_q;
    logic              rsp_err_q;
    logic [7:0]        err_count_q;

    logic [1:0]        gnt;
    logic              sel;
    logic              accept;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_wr;
    logic [3:0]        req_ctl;
    logic              req_err;

    rr_arb2 u_rr_arb2 (
        .req0_i (p0_valid),
        .req1_i (p1_valid),
        .last_i (last_q),
        .gnt_o  (gnt)
    );

    assign sel    = gnt[1];
    assign accept = (state_q == StIdle) && (|gnt);

    always_comb begin
        req_addr  = sel ? p1_addr  : p0_addr;
        req_wdata = sel ? p1_wdata : p0_wdata;
        req_wr    = sel ? p1_wr    : p0_wr;
        req_ctl   = sel ? p1_ctl   : p0_ctl;
        // Any address bit above the word window makes the access illegal.
        req_err   = ctl_bad(req_ctl, req_addr[1:0]) || ((req_addr >> (MEM_AW + 2)) != '0);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (|gnt) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ctl_q       <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q <= sel;
                last_q  <= sel;
                wr_q    <= req_wr;
                err_q   <= req_err;
                addr_q  <= 32'(req_addr);
                wdata_q <= req_wdata;
                ctl_q   <= req_ctl;
            end
            if (state_q == StAccess) begin
                rsp_data_q <= (wr_q || err_q) ? '0 : mem_rdata;
                rsp_err_q  <= err_q;
                if (err_q && (err_count_q != 8'hFF)) begin
                    err_count_q <= err_count_q + 8'd1;
                end
            end
        end
    end

    always_comb begin
        p0_ready     = accept && gnt[0] && !rst;
        p1_ready     = accept && gnt[1] && !rst;
        p0_rsp_valid = (state_q == StResp) && !owner_q;
        p1_rsp_valid = (state_q == StResp) && owner_q;
        p0_rsp_data  = p0_rsp_valid ? rsp_data_q : '0;
        p1_rsp_data  = p1_rsp_valid ? rsp_data_q : '0;
        p0_rsp_err   = p0_rsp_valid && rsp_err_q;
        p1_rsp_err   = p1_rsp_valid && rsp_err_q;
        mem_addr     = addr_q;
        mem_wdata    = wdata_q;
        mem_ctl      = ctl_q;
        mem_wr       = (state_q == StAccess) && wr_q && !err_q && !rst;
        err_count    = err_count_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural byte-lane data memory.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_valid = 1'b0, p1_valid = 1'b0;
    logic        p0_ready, p1_ready;
    logic [31:0] p0_addr = '0, p1_addr = '0;
    logic [31:0] p0_wdata = '0, p1_wdata = '0;
    logic        p0_wr = 1'b0, p1_wr = 1'b0;
    logic [3:0]  p0_ctl = '0, p1_ctl = '0;
    logic        p0_rsp_valid, p1_rsp_valid;
    logic [31:0] p0_rsp_data, p1_rsp_data;
    logic        p0_rsp_err, p1_rsp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr;
    logic [3:0]  mem_ctl;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .p0_valid     (p0_valid),
        .p1_valid     (p1_valid),
        .p0_ready     (p0_ready),
        .p1_ready     (p1_ready),
        .p0_addr      (p0_addr),
        .p1_addr      (p1_addr),
        .p0_wdata     (p0_wdata),
        .p1_wdata     (p1_wdata),
        .p0_wr        (p0_wr),
        .p1_wr        (p1_wr),
        .p0_ctl       (p0_ctl),
        .p1_ctl       (p1_ctl),
        .p0_rsp_valid (p0_rsp_valid),
        .p1_rsp_valid (p1_rsp_valid),
        .p0_rsp_data  (p0_rsp_data),
        .p1_rsp_data  (p1_rsp_data),
        .p0_rsp_err   (p0_rsp_err),
        .p1_rsp_err   (p1_rsp_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wr       (mem_wr),
        .mem_ctl      (mem_ctl),
        .mem_rdata    (mem_rdata),
        .err_count    (err_count)
    );

    // Data memory model: lane-aware stores, sign/zero-extending loads.
    logic [31:0] mem [0:1023];
    logic [31:0] rd_word, rd_sh;

    always @(posedge clk) begin
        if (mem_wr) begin
            case (mem_ctl)
                MEM_SB:  mem[mem_addr[11:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
                MEM_SH:  mem[mem_addr[11:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
                MEM_SW:  mem[mem_addr[11:2]] <= mem_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_word = mem[mem_addr[11:2]];
        rd_sh   = rd_word >> {mem_addr[1:0], 3'b000};
        case (mem_ctl)
            MEM_LB:  mem_rdata = {{24{rd_sh[7]}}, rd_sh[7:0]};
            MEM_LBU: mem_rdata = {24'h0, rd_sh[7:0]};
            MEM_LH:  mem_rdata = {{16{rd_sh[15]}}, rd_sh[15:0]};
            MEM_LHU: mem_rdata = {16'h0, rd_sh[15:0]};
            MEM_LW:  mem_rdata = rd_word;
            default: mem_rdata = '0;
        endcase
    end

    // Runs one transaction on one port and reports what was observed.
    task automatic do_xact(input bit port, input logic wr, input logic [3:0] ctl,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output bit acc, output int lat, output logic [31:0] data,
                           output logic err, output bit saw_wr, output bit other_v,
                           output bit extra);
        acc = 0; lat = -1; data = '0; err = 1'b0; saw_wr = 0; other_v = 0; extra = 0;
        @(negedge clk);
        if (port) begin
            p1_addr = addr; p1_wdata = wdata; p1_wr = wr; p1_ctl = ctl; p1_valid = 1'b1;
        end else begin
            p0_addr = addr; p0_wdata = wdata; p0_wr = wr; p0_ctl = ctl; p0_valid = 1'b1;
        end
        #1;
        for (int i = 0; i < 8; i++) begin
            if (port ? p1_ready : p0_ready) begin
                acc = 1;
                break;
            end
            @(negedge clk); #1;
        end
        @(negedge clk);
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        #1;
        if (!acc) return;
        for (int j = 1; j <= 3; j++) begin
            if (j > 1) begin
                @(negedge clk); #1;
            end
            if (mem_wr) saw_wr = 1;
            if (port ? p0_rsp_valid : p1_rsp_valid) other_v = 1;
            if (port ? p1_rsp_valid : p0_rsp_valid) begin
                if (lat < 0) begin
                    lat  = j;
                    data = port ? p1_rsp_data : p0_rsp_data;
                    err  = port ? p1_rsp_err : p0_rsp_err;
                end else begin
                    extra = 1;
                end
            end
        end
    endtask

    task automatic test_reset();
        p0_valid = 1'b1;
        p1_valid = 1'b1;
        #12;
        n_cmp++;
        if ({p0_ready, p1_ready} !== 2'b00) begin
            n_bad++; $display("FAIL reset_ready: got %b want 00", {p0_ready, p1_ready});
        end
        n_cmp++;
        if ({p0_rsp_valid, p1_rsp_valid, mem_wr} !== 3'b000) begin
            n_bad++; $display("FAIL reset_strobes: got %b want 000",
                              {p0_rsp_valid, p1_rsp_valid, mem_wr});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata, mem_ctl} !== 68'h0) begin
            n_bad++; $display("FAIL reset_mem_bus: got %h %h %h want 0", mem_addr, mem_wdata,
                              mem_ctl);
        end
        n_cmp++;
        if (err_count !== 8'h00) begin
            n_bad++; $display("FAIL reset_err_count: got %h want 00", err_count);
        end
        @(negedge clk);
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        int g[$];
        int want[4] = '{0, 1, 0, 1};
        @(negedge clk);
        p0_addr = 32'h0; p0_ctl = MEM_LW; p0_wr = 1'b0; p0_valid = 1'b1;
        p1_addr = 32'h4; p1_ctl = MEM_LW; p1_wr = 1'b0; p1_valid = 1'b1;
        #1;
        for (int i = 0; i < 14; i++) begin
            if (p0_ready && p1_ready) begin
                n_cmp++; n_bad++; $display("FAIL rr_onehot: got 11 want one winner");
            end
            if (p0_ready) g.push_back(0);
            if (p1_ready) g.push_back(1);
            @(negedge clk); #1;
        end
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (g.size() !== 5) begin
            n_bad++; $display("FAIL rr_grant_count: got %0d want 5", g.size());
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (k >= g.size()) begin
                n_bad++; $display("FAIL rr_grant_%0d: got none want p%0d", k, want[k]);
            end else if (g[k] !== want[k]) begin
                n_bad++; $display("FAIL rr_grant_%0d: got p%0d want p%0d", k, g[k], want[k]);
            end
        end
    endtask

    task automatic test_store_load();
        bit acc, sw, ov, ex; int lat; logic [31:0] d; logic e;
        do_xact(0, 1'b1, MEM_SW, 32'h10, 32'hDEADBEEF, acc, lat, d, e, sw, ov, ex);
        n_cmp++;
        if (!acc || lat !== 2 || ex || ov) begin
            n_bad++; $display("FAIL sw_timing: got acc=%0d lat=%0d extra=%0d other=%0d want 1 2 0 0",
                              acc, lat, ex, ov);
        end
        n_cmp++;
        if ({sw, e, d} !== {1'b1, 1'b0, 32'h0}) begin
            n_bad++; $display("FAIL sw_resp: got wr=%0d err=%0d data=%h want 1 0 0", sw, e, d);
        end
        do_xact(0, 1'b0, MEM_LW, 32'h10, 32'h0, acc, lat, d, e, sw, ov, ex);
        n_cmp++;
        if (!acc || lat !== 2 || ex || sw) begin
            n_bad++; $display("FAIL lw_timing: got acc=%0d lat=%0d extra=%0d wr=%0d want 1 2 0 0",
                              acc, lat, ex, sw);
        end
        n_cmp++;
        if ({e, d} !== {1'b0, 32'hDEADBEEF}) begin
            n_bad++; $display("FAIL lw_data: got err=%0d data=%h want 0 deadbeef", e, d);
        end
    endtask

    task automatic test_bytes();
        bit acc, sw, ov, ex; int lat; logic [31:0] d; logic e;
        do_xact(0, 1'b1, MEM_SW, 32'h20, 32'h11223344, acc, lat, d, e, sw, ov, ex);
        do_xact(0, 1'b1, MEM_SB, 32'h21, 32'h000000AB, acc, lat, d, e, sw, ov, ex);
        do_xact(0, 1'b0, MEM_LBU, 32'h21, 32'h0, acc, lat, d, e, sw, ov, ex);
        n_cmp++;
        if ({e, d} !== {1'b0, 32'h000000AB}) begin
            n_bad++; $display("FAIL lbu_21: got err=%0d data=%h want 0 000000ab", e, d);
        end
        do_xact(1, 1'b0, MEM_LW, 32'h20, 32'h0, acc, lat, d, e, sw, ov, ex);
        n_cmp++;
        if ({e, d, ov} !== {1'b0, 32'h1122AB44, 1'b0}) begin
            n_bad++; $display("FAIL lw_20_p1: got err=%0d data=%h other=%0d want 0 1122ab44 0",
                              e, d, ov);
        end
        do_xact(0, 1'b1, MEM_SB, 32'h80, 32'h00000080, acc, lat, d, e, sw, ov, ex);
        do_xact(0, 1'b0, MEM_LB, 32'h80, 32'h0, acc, lat, d, e, sw, ov, ex);
        n_cmp++;
        if ({e, d} !== {1'b0, 32'hFFFFFF80}) begin
            n_bad++; $display("FAIL lb_80: got err=%0d data=%h want 0 ffffff80", e, d);
        end
    endtask

    task automatic test_reset_abort();
        bit acc, sw, ov, ex; int lat; logic [31:0] d; logic e;
        bit seen;
        do_xact(0, 1'b1, MEM_SW, 32'h40, 32'hCAFEF00D, acc, lat, d, e, sw, ov, ex);
        @(negedge clk);
        p0_addr = 32'h40; p0_wdata = 32'h12345678; p0_wr = 1'b1; p0_ctl = MEM_SW;
        p0_valid = 1'b1;
        #1;
        seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (p0_ready) seen = 1;
            else begin
                @(negedge clk); #1;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL abort_accept: got no ready want ready");
        end
        @(posedge clk); #1;
        p0_valid = 1'b0;
        n_cmp++;
        if (mem_wr !== 1'b1) begin
            n_bad++; $display("FAIL abort_access_wr: got %b want 1", mem_wr);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({mem_wr, p0_rsp_valid, mem_addr} !== {1'b0, 1'b0, 32'h0}) begin
            n_bad++; $display("FAIL abort_in_reset: got wr=%b rv=%b addr=%h want 0 0 0",
                              mem_wr, p0_rsp_valid, mem_addr);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (i == 1) rst = 1'b0;
            if (p0_rsp_valid || p1_rsp_valid || (rst && mem_wr)) seen = 1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++; $display("FAIL abort_no_resp: got a response or write want none");
        end
        do_xact(0, 1'b0, MEM_LW, 32'h40, 32'h0, acc, lat, d, e, sw, ov, ex);
        n_cmp++;
        if ({e, d} !== {1'b0, 32'hCAFEF00D}) begin
            n_bad++; $display("FAIL abort_prior: got err=%0d data=%h want 0 cafef00d", e, d);
        end
        n_cmp++;
        if (err_count !== 8'h00) begin
            n_bad++; $display("FAIL abort_err_count: got %h want 00", err_count);
        end
    endtask

    task automatic test_errors();
        bit acc, sw, ov, ex; int lat; logic [31:0] d; logic e;
        n_cmp++;
        if (err_count !== 8'h00) begin
            n_bad++; $display("FAIL err_count_before: got %h want 00", err_count);
        end
        do_xact(1, 1'b0, MEM_LH, 32'h13, 32'h0, acc, lat, d, e, sw, ov, ex);
        n_cmp++;
        if (!acc || lat !== 2 || {e, d, sw, ov} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL lh_misaligned: got lat=%0d err=%0d data=%h wr=%0d want 2 1 0 0",
                              lat, e, d, sw);
        end
        n_cmp++;
        if (err_count !== 8'h01) begin
            n_bad++; $display("FAIL err_count_1: got %h want 01", err_count);
        end
        do_xact(0, 1'b1, MEM_SW, 32'h1000, 32'h55555555, acc, lat, d, e, sw, ov, ex);
        n_cmp++;
        if ({e, d, sw} !== {1'b1, 32'h0, 1'b0}) begin
            n_bad++; $display("FAIL sw_window: got err=%0d data=%h wr=%0d want 1 0 0", e, d, sw);
        end
        do_xact(0, 1'b0, 4'hF, 32'h0, 32'h0, acc, lat, d, e, sw, ov, ex);
        n_cmp++;
        if ({e, d} !== {1'b1, 32'h0}) begin
            n_bad++; $display("FAIL bad_ctl: got err=%0d data=%h want 1 0", e, d);
        end
        do_xact(0, 1'b1, MEM_SH, 32'h42, 32'h0000BEEF, acc, lat, d, e, sw, ov, ex);
        n_cmp++;
        if ({e, sw, err_count} !== {1'b0, 1'b1, 8'h03}) begin
            n_bad++; $display("FAIL sh_aligned: got err=%0d wr=%0d cnt=%h want 0 1 03",
                              e, sw, err_count);
        end
    endtask

    task automatic test_saturate();
        bit acc, sw, ov, ex; int lat; logic [31:0] d; logic e;
        int not_err = 0;
        for (int i = 0; i < 300; i++) begin
            do_xact(i[0], 1'b0, MEM_LW, 32'h2, 32'h0, acc, lat, d, e, sw, ov, ex);
            if (e !== 1'b1) not_err++;
            if (i == 250) begin
                n_cmp++;
                if (err_count !== 8'hFE) begin
                    n_bad++; $display("FAIL err_count_254: got %h want fe", err_count);
                end
            end
        end
        n_cmp++;
        if (not_err !== 0) begin
            n_bad++; $display("FAIL sat_all_err: got %0d non-error want 0", not_err);
        end
        n_cmp++;
        if (err_count !== 8'hFF) begin
            n_bad++; $display("FAIL err_count_sat: got %h want ff", err_count);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_store_load();
        test_bytes();
        test_reset_abort();
        test_errors();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
